ring_sampler: RTL
=================

Name: ring_sampler

Overview:
- Reader side of the self-timed ring built from ring stages.
- Drives each stage's reset and init-value inputs, samples all stage outputs on the system clock, and XOR-folds them into one raw bit per cycle.
- Packs raw bits into words and presents them on a valid/ready interface to the post-processing/conditioning block.
- Includes a stuck-bit health check.

Parameters:
- N_STAGES, 63: number of ring stages and tap width.
- INIT_PATTERN, 63'h5555_5555_5555_5555 (truncated to N_STAGES): per-stage i_init_val driven during init. Must contain both 0s and 1s so that tokens and bubbles exist.
- INIT_CYCLES, 4: clocks o_ring_reset is held high.
- SETTLE_CYCLES, 16: raw bits discarded after ring release.
- WORD_W, 32: output word width.
- STUCK_LIMIT, 64: consecutive identical raw bits that flag a health failure. Must be ≥ 2.

Ports:
- i_clk, in, 1: system clock.
- i_reset, in, 1: asynchronous, active-high reset.
- i_enable, in, 1: run request, level sensitive.
- i_ring, in, N_STAGES: stage outputs. Asynchronous to i_clk.
- o_ring_reset, out, 1: drives i_reset of every stage.
- o_ring_init, out, N_STAGES: drives i_init_val of each stage. Constant INIT_PATTERN.
- o_data, out, WORD_W: collected word. First bit collected ends in the MSB.
- o_valid, out, 1: o_data valid.
- i_ready, in, 1: consumer accepts o_data.
- o_busy, out, 1: FSM not in IDLE.
- o_error, out, 1: sticky stuck-bit failure.

Behaviour:
- Reset values (async, while i_reset high):
  - o_ring_reset=1; o_valid=0; o_data=0; o_busy=0; o_error=0.
  - FSM=IDLE; all counters and synchronizer flops=0.
- Sampling: each i_ring bit passes a 2-flop synchronizer. raw = XOR of all synchronized bits, registered. Latency from i_ring to raw bit is 3 clocks.
- FSM states:
  - IDLE: o_ring_reset=1. If i_enable=1 and o_error=0, go to INIT.
  - INIT: o_ring_reset=1 for exactly INIT_CYCLES clocks, then go to SETTLE.
  - SETTLE: o_ring_reset=0. Discard SETTLE_CYCLES raw bits, then go to COLLECT.
  - COLLECT: each clock, o_data shift register <= {shreg[WORD_W-2:0], raw}. After WORD_W bits, load the output register, assert o_valid, go to PRESENT.
  - PRESENT: hold o_data and o_valid=1 until i_ready=1 is sampled. On that clock, o_valid drops the next cycle.
    - If i_enable=1, return directly to COLLECT; the ring keeps running and is not re-initialised.
    - Otherwise go to IDLE.
- Handshake rules:
  - o_data is stable while o_valid=1.
  - The transfer happens on a clock edge with o_valid&i_ready.
  - i_ready while o_valid=0 is ignored.
- Disable: i_enable=0 in INIT, SETTLE or COLLECT aborts to IDLE next clock. The partial word is dropped and o_valid stays 0. In PRESENT, the word is still held until accepted.
- Health check:
  - Active in SETTLE, COLLECT and PRESENT.
  - A run counter counts consecutive equal raw bits and saturates.
  - When run length reaches STUCK_LIMIT: o_error=1 (sticky until i_reset), FSM goes to IDLE, o_valid=0, and the pending word is discarded.
  - o_error has priority over the i_ready handshake in the same cycle.
- Simultaneous events: error beats disable, and disable beats word completion.
- Every word delivered after a new INIT has seen SETTLE_CYCLES discarded bits first.
- i_reset mid-operation clears everything immediately. o_ring_reset goes high asynchronously.

Test Plan:
- Reset: assert i_reset with i_enable=1 → o_ring_reset=1, o_valid=0, o_error=0, o_busy=0. After release, o_ring_reset stays 1 for 1 (IDLE) + 4 (INIT) clocks, then goes 0.
- Single word: N_STAGES=3. Bench drives i_ring so that raw alternates 1,0,1,0… starting after settle. With i_ready=1 → o_data=32'hAAAA_AAAA, o_valid high for exactly 1 clock, and the first word appears 3+16+32 clocks after ring release.
- Backpressure: hold i_ready=0 for 10 clocks after o_valid → o_data and o_valid stable for all 10 clocks. Raise i_ready → one transfer, and the next word follows WORD_W clocks later with no INIT.
- Stuck ring: drive i_ring constant 3'b001 → o_error=1 exactly STUCK_LIMIT clocks after the first constant raw bit. FSM goes to IDLE, o_ring_reset=1, and no o_valid follows. Re-asserting i_enable has no effect until i_reset.
- Abort: drop i_enable at bit 20 of COLLECT → next clock o_busy=0, o_ring_reset=1, o_valid never asserts. Re-enable → full INIT and SETTLE sequence repeats.
- Async reset in PRESENT with o_valid=1 → o_valid=0 within the same timestep, without waiting for a clock edge.

Source files
------------

// File: rtl/ring_sampler.sv
// Reader side of a self-timed ring: holds the ring in reset/init, samples and XOR-folds
// the stage outputs into raw bits, packs them into words on a valid/ready port, and flags stuck output.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | ring held in reset, waiting for i_enable (blocked by o_error)
//   S_INIT    | ring held in reset with init values for INIT_CYCLES clocks
//   S_SETTLE  | ring released, raw bits discarded (pipeline flush + settle)
//   S_COLLECT | raw bits shifted into the word, one per clock
//   S_PRESENT | word held on o_data with o_valid until accepted
module ring_sampler #(
  parameter int                  N_STAGES      = 63,
  parameter logic [N_STAGES-1:0] INIT_PATTERN  = N_STAGES'(63'h5555_5555_5555_5555),
  parameter int                  INIT_CYCLES   = 4,
  parameter int                  SETTLE_CYCLES = 16,
  parameter int                  WORD_W        = 32,
  parameter int                  STUCK_LIMIT   = 64
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [N_STAGES-1:0] i_ring,
  output logic                o_ring_reset,
  output logic [N_STAGES-1:0] o_ring_init,
  output logic [WORD_W-1:0]   o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_error
);

  // Raw bits seen in the first PIPE_LAT settle clocks still reflect the ring in reset,
  // so SETTLE is stretched by the sampling latency before the SETTLE_CYCLES discard.
  localparam int PIPE_LAT    = 3;
  localparam int SETTLE_LOAD = SETTLE_CYCLES + PIPE_LAT - 1;
  localparam int MAX_A       = (INIT_CYCLES - 1 > SETTLE_LOAD) ? INIT_CYCLES - 1 : SETTLE_LOAD;
  localparam int CNT_MAX     = (MAX_A > WORD_W - 1) ? MAX_A : WORD_W - 1;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int RUN_W       = $clog2(STUCK_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SETTLE,
    S_COLLECT,
    S_PRESENT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N_STAGES-1:0] r_sync1;
  logic [N_STAGES-1:0] r_sync2;
  logic                r_raw;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [WORD_W-2:0]   r_shreg;
  logic [WORD_W-1:0]   w_word;
  logic [WORD_W-1:0]   r_data;
  logic                r_valid;
  logic                r_error;
  logic [RUN_W-1:0]    r_run;
  logic                r_last;
  logic                w_health_on;
  logic                w_run_cont;
  logic                w_stuck;
  logic                w_cnt_tc;
  logic                w_word_done;
  logic                w_accept;

  assign w_health_on = (r_state == S_SETTLE) || (r_state == S_COLLECT) || (r_state == S_PRESENT);
  assign w_run_cont  = (r_run != '0) && (r_raw == r_last);
  assign w_stuck     = w_health_on && w_run_cont && (r_run == RUN_W'(STUCK_LIMIT - 1));
  assign w_cnt_tc    = (r_cnt == '0);
  assign w_word      = {r_shreg, r_raw};

  // Priority inside each state: stuck error, then disable, then count/word completion.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_word_done  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && !r_error) begin
          w_state_next = S_INIT;
          w_cnt_next   = CNT_W'(INIT_CYCLES - 1);
        end
      end
      S_INIT: begin
        if (!i_enable) begin
          w_state_next = S_IDLE;
        end else if (w_cnt_tc) begin
          w_state_next = S_SETTLE;
          w_cnt_next   = CNT_W'(SETTLE_LOAD);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (w_stuck || !i_enable) begin
          w_state_next = S_IDLE;
        end else if (w_cnt_tc) begin
          w_state_next = S_COLLECT;
          w_cnt_next   = CNT_W'(WORD_W - 1);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_COLLECT: begin
        if (w_stuck || !i_enable) begin
          w_state_next = S_IDLE;
        end else if (w_cnt_tc) begin
          w_state_next = S_PRESENT;
          w_word_done  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      S_PRESENT: begin
        if (w_stuck) begin
          w_state_next = S_IDLE;
        end else if (i_ready) begin
          w_accept = 1'b1;
          if (i_enable) begin
            w_state_next = S_COLLECT;
            w_cnt_next   = CNT_W'(WORD_W - 1);
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_raw   <= 1'b0;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
      r_run   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sync1 <= i_ring;
      r_sync2 <= r_sync1;
      r_raw   <= ^r_sync2;
      if (r_state == S_COLLECT) begin
        r_shreg <= w_word[WORD_W-2:0];
      end
      if (w_word_done) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_stuck || w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_stuck) begin
        r_error <= 1'b1;
      end
      // Run length of identical raw bits, restarted whenever the check is inactive.
      if (!w_health_on) begin
        r_run <= '0;
      end else if (w_run_cont) begin
        if (r_run != RUN_W'(STUCK_LIMIT)) begin
          r_run <= r_run + RUN_W'(1);
        end
      end else begin
        r_run <= RUN_W'(1);
      end
      r_last <= r_raw;
    end
  end

  assign o_ring_reset = (r_state == S_IDLE) || (r_state == S_INIT);
  assign o_ring_init  = INIT_PATTERN;
  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_busy       = (r_state != S_IDLE);
  assign o_error      = r_error;

endmodule
